// File: rtl/ps2_keyboard_pkg.sv
// Shared constants and types for the PS/2 keyboard peripheral:
// register indices, STATUS bit positions and the receiver state encoding.
package kbd_pkg;

    localparam logic [1:0] KBD_REG_STATUS = 2'd0;
    localparam logic [1:0] KBD_REG_DATA   = 2'd1;
    localparam logic [1:0] KBD_REG_POP    = 2'd2;
    localparam logic [1:0] KBD_REG_CTRL   = 2'd3;

    localparam int KBD_STAT_NOT_EMPTY = 0;
    localparam int KBD_STAT_FULL      = 1;
    localparam int KBD_STAT_OVF       = 2;
    localparam int KBD_STAT_PERR      = 3;
    localparam int KBD_STAT_FERR      = 4;
    localparam int KBD_STAT_COUNT_LSB = 8;

    // CTRL bit that enables the interrupt output when PS2_KBD_IRQ_EN is defined
    localparam int KBD_CTRL_IRQ_EN = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

endpackage

// File: rtl/ps2_keyboard_if.sv
// CPU-side memory-mapped bus between the memory controller and the keyboard
// peripheral; signal names follow the controller's keyboard_* ports.
interface ps2_keyboard_if;
    logic [31:0] addr_in;
    logic [31:0] data_in;
    logic [3:0]  write_enable_in;
    logic [31:0] data_out;

    modport master (output addr_in, output data_in, output write_enable_in, input data_out);
    modport slave  (input addr_in, input data_in, input write_enable_in, output data_out);
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 frame receiver: synchronizes and debounces the raw lines, decodes
// 11-bit frames on falling clock edges and aborts stalled frames.
module ps2_rx
    import kbd_pkg::*;
#(
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       parity_err_pulse_o,
    output logic       frame_err_pulse_o
);

    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0] raw_lines;
    logic [1:0] filt_lines;
    assign raw_lines = {ps2_data_in, ps2_clk_in};

    // Bit 0 is the PS/2 clock, bit 1 the data; both get identical delay so
    // their relative timing is preserved.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cond
            logic [1:0]    sync_q;
            logic [FW-1:0] stable_cnt_q;
            logic          filt_q;

            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    sync_q       <= 2'b11;
                    stable_cnt_q <= '0;
                    filt_q       <= 1'b1;
                end else begin
                    sync_q <= {sync_q[0], raw_lines[gi]};
                    if (sync_q[1] == filt_q) begin
                        stable_cnt_q <= '0;
                    end else if (stable_cnt_q == FW'(FILTER_CYCLES - 1)) begin
                        filt_q       <= sync_q[1];
                        stable_cnt_q <= '0;
                    end else begin
                        stable_cnt_q <= stable_cnt_q + 1'b1;
                    end
                end
            end

            assign filt_lines[gi] = filt_q;
        end
    endgenerate

    logic clk_prev_q;
    logic fall_edge;
    logic data_bit;

    assign fall_edge = clk_prev_q & ~filt_lines[0];
    assign data_bit  = filt_lines[1];

    rx_state_e     state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] idle_cnt_q, idle_cnt_d;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            clk_prev_q <= 1'b1;
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            clk_prev_q <= filt_lines[0];
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        bit_cnt_d          = bit_cnt_q;
        shift_d            = shift_q;
        parity_d           = parity_q;
        byte_valid_o       = 1'b0;
        parity_err_pulse_o = 1'b0;
        frame_err_pulse_o  = 1'b0;

        if (state_q == IDLE || fall_edge) begin
            idle_cnt_d = '0;
        end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end

        if (fall_edge) begin
            unique case (state_q)
                IDLE: begin
                    if (!data_bit) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {data_bit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    parity_d = data_bit;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    // A bad stop bit is reported as a framing error even if parity is also wrong.
                    if (!data_bit) begin
                        frame_err_pulse_o = 1'b1;
                    end else if (^{shift_q, parity_q}) begin
                        byte_valid_o = 1'b1;
                    end else begin
                        parity_err_pulse_o = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && idle_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d = IDLE;
        end
    end

    assign byte_o = shift_q;

endmodule

// File: rtl/ps2_keyboard.sv
// Memory-mapped PS/2 keyboard: scan-code FIFO plus STATUS/DATA/POP/CTRL registers.
// Define PS2_KBD_IRQ_EN to add the irq_out port and the CTRL interrupt-enable bit.
module ps2_keyboard
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           ps2_clk_in,
    input  logic           ps2_data_in,
    ps2_keyboard_if.slave  bus
`ifdef PS2_KBD_IRQ_EN
    ,
    output logic           irq_out
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_perr;
    logic       rx_ferr;

    ps2_rx #(
        .FILTER_CYCLES (FILTER_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .ps2_clk_in        (ps2_clk_in),
        .ps2_data_in       (ps2_data_in),
        .byte_o            (rx_byte),
        .byte_valid_o      (rx_valid),
        .parity_err_pulse_o(rx_perr),
        .frame_err_pulse_o (rx_ferr)
    );

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          ovf_q, perr_q, ferr_q;
    logic [31:0]   data_out_q, data_out_d;

    logic       is_write;
    logic [1:0] reg_sel;
    logic       empty, full;
    logic       pop, push, ovf_set;
    logic [2:0] flag_clr;

    assign is_write = |bus.write_enable_in;
    assign reg_sel  = bus.addr_in[3:2];
    assign empty    = (count_q == '0);
    assign full     = (count_q == (AW+1)'(FIFO_DEPTH));

    // Popping frees a slot this same cycle, so a push into a full FIFO still lands.
    assign pop      = is_write && (reg_sel == KBD_REG_POP) && !empty;
    assign push     = rx_valid && (!full || pop);
    assign ovf_set  = rx_valid && full && !pop;
    assign flag_clr = (is_write && reg_sel == KBD_REG_CTRL) ? bus.data_in[2:0] : 3'b000;

    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rx_byte;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            data_out_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q    <= count_q + (AW+1)'(push) - (AW+1)'(pop);
            // Setting wins over a simultaneous clear so no event is lost.
            ovf_q      <= ovf_set | (ovf_q  & ~flag_clr[0]);
            perr_q     <= rx_perr | (perr_q & ~flag_clr[1]);
            ferr_q     <= rx_ferr | (ferr_q & ~flag_clr[2]);
            data_out_q <= data_out_d;
        end
    end

`ifdef PS2_KBD_IRQ_EN
    logic irq_en_q;
    logic irq_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (is_write && reg_sel == KBD_REG_CTRL) begin
                irq_en_q <= bus.data_in[KBD_CTRL_IRQ_EN];
            end
            irq_q <= irq_en_q & (!empty | ovf_q);
        end
    end

    assign irq_out = irq_q;
`endif

    always_comb begin
        data_out_d = '0;
        unique case (reg_sel)
            KBD_REG_STATUS: begin
                data_out_d[KBD_STAT_NOT_EMPTY] = !empty;
                data_out_d[KBD_STAT_FULL]      = full;
                data_out_d[KBD_STAT_OVF]       = ovf_q;
                data_out_d[KBD_STAT_PERR]      = perr_q;
                data_out_d[KBD_STAT_FERR]      = ferr_q;
                data_out_d[KBD_STAT_COUNT_LSB +: 8] = 8'(count_q);
            end
            KBD_REG_DATA: begin
                if (!empty) begin
                    data_out_d[7:0] = mem_q[rd_ptr_q];
                end
            end
            KBD_REG_CTRL: begin
`ifdef PS2_KBD_IRQ_EN
                data_out_d[KBD_CTRL_IRQ_EN] = irq_en_q;
`endif
            end
            default: data_out_d = '0;
        endcase
    end

    assign bus.data_out = data_out_q;

    // Only addr[3:2] and a few CTRL bits are decoded.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus.addr_in[31:4], bus.addr_in[1:0], bus.data_in[31:3]};

endmodule

// File: doc/ps2_keyboard.md
Name: ps2_keyboard

Overview:
- Memory-mapped PS/2 keyboard peripheral on the CPU clock domain (clk_50mhz).
- Receives scan codes from a keyboard on the PMOD-B header (clock and data lines).
- Decodes and checks each frame, then buffers the bytes in a FIFO.
- Connects to the memory controller's keyboard_* bus ports and presents status, data, pop and control registers to the CPU.

Parameters:
- FIFO_DEPTH, 16, scan-code FIFO entries; must be a power of 2, at most 128.
- FILTER_CYCLES, 8, consecutive identical samples needed before the filtered PS/2 clock or data changes.
- TIMEOUT_CYCLES, 50000, idle cycles mid-frame before the receiver aborts the frame (1 ms at 50 MHz).

Ports:
- clk_in  input  1  CPU clock.
- rst_in  input  1  asynchronous, active-high reset.
- ps2_clk_in  input  1  raw PS/2 clock, asynchronous.
- ps2_data_in  input  1  raw PS/2 data, asynchronous.
- addr_in  input  32  bus address; only addr_in[3:2] is decoded.
- data_in  input  32  bus write data.
- write_enable_in  input  4  byte write enables; any nonzero bit means a write.
- data_out  output  32  registered read data.

Behaviour:
- Reset (async, rst_in=1): FIFO empty, all sticky flags 0, receiver in IDLE, data_out=0, filtered clock/data=1.
- Input conditioning:
  - Two-flop synchronizer, then the FILTER_CYCLES stability filter.
  - Edge event = filtered clock going 1->0; data is sampled from filtered data on that cycle.
- Receiver FSM, one transition per edge event:
  - IDLE: data=0 -> DATA with bit count 0. data=1 -> stay in IDLE (spurious start).
  - DATA: shift data in LSB first; after 8 bits -> PARITY.
  - PARITY: record the parity bit -> STOP.
  - STOP: data=1 and odd parity correct (ones in the byte plus parity bit is odd) -> push byte, go IDLE. Parity bad -> set PERR, no push, go IDLE. Stop bit=0 -> set FERR, no push, go IDLE.
- Timeout: in any non-IDLE state, a counter reloads on every edge event. After TIMEOUT_CYCLES cycles with no edge -> IDLE, partial byte discarded, no flag set.
- FIFO:
  - Push and pop on the same cycle: both happen and the count is unchanged, including when full.
  - Push when full and no pop: byte dropped, OVF set.
  - Pop when empty: ignored.
- Register map (addr_in[3:2]):
  - 0 STATUS, read-only: [0] not-empty, [1] full, [2] OVF, [3] PERR, [4] FERR, [15:8] count, zero-extended to 8 bits.
  - 1 DATA, read-only: [7:0] FIFO head, or 0 when empty; upper bits 0. Reading does not pop.
  - 2 POP: any write pops one entry; reads return 0.
  - 3 CTRL: write-1-to-clear, bit0 clears OVF, bit1 clears PERR, bit2 clears FERR; reads return 0.
  - A flag set and cleared on the same cycle ends up set.
- Read timing: data_out is registered. The value for the address presented in cycle N appears in cycle N+1.
- A pop write in cycle N is visible in a STATUS read addressed in cycle N+1.

Optional Feature:
- Macro: PS2_KBD_IRQ_EN.
- When defined:
  - Adds output port irq_out (1 bit), registered, reset value 0.
  - CTRL bit 8 becomes a read/write IRQ-enable bit, reset value 0, and CTRL reads return it.
  - irq_out = IRQ-enable AND (not-empty OR OVF).
- When not defined: there is no irq_out port, and CTRL bit 8 is ignored.

Decomposition:
- Package kbd_pkg holds:
  - register index constants: KBD_REG_STATUS=0, KBD_REG_DATA=1, KBD_REG_POP=2, KBD_REG_CTRL=3;
  - STATUS bit index constants;
  - the receiver state enum {IDLE, DATA, PARITY, STOP}.
- One sub-module, ps2_rx, contains the synchronizer, filter, FSM and timeout. Its outputs are byte[7:0], byte_valid (1-cycle pulse), parity_err_pulse and frame_err_pulse.
- The FIFO and register logic stay in the top module.

Test Plan:
- Single byte: send 0x1C with parity 0 and stop 1. STATUS reads 0x0000_0101 and DATA reads 0x0000_001C. Write to POP; STATUS then reads 0x0000_0000.
- Parity error: send 0x1C with parity 1. STATUS reads 0x0000_0008 and the FIFO stays empty. Write 0x2 to CTRL; STATUS reads 0.
- Overflow with FIFO_DEPTH=16: send bytes 0x00..0x10, 17 in total. STATUS reads 0x0000_1007 and DATA reads 0x00. Write 0x1 to CTRL; STATUS reads 0x0000_1003.
- Timeout: send a start bit plus 3 data bits, then hold idle for TIMEOUT_CYCLES+10 cycles. Then send a full 0xF0 frame with parity 1. The FIFO holds exactly 0xF0, with no PERR and no FERR.
- Frame error and glitch: send 0x1C with stop bit 0 -> STATUS reads 0x0000_0010. A 3-cycle low pulse on ps2_clk_in produces no edge event and no state change.
- Reset mid-frame: assert rst_in after 5 bits have been received -> data_out=0 and the FIFO is empty immediately. A following full 0x1C frame is received correctly.
